// File: rtl/crossbar_nxm.sv
// N-master by M-slave request/ack crossbar. Each slave port owns an IDLE/BUSY
// arbiter (round-robin or fixed priority) and a 16-bit completed-transaction counter.
module crossbar_nxm #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned N_SLAVES  = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ARB_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
  output logic [N_SLAVES-1:0]           s_req,
  output logic [N_SLAVES-1:0]           s_cmd,
  output logic [N_SLAVES*ADDR_W-1:0]    s_addr,
  output logic [N_SLAVES*DATA_W-1:0]    s_wdata,
  input  logic [N_SLAVES-1:0]           s_ack,
  input  logic [N_SLAVES*DATA_W-1:0]    s_rdata,
  output logic [N_SLAVES*16-1:0]        grant_cnt
);

  localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 0;
  localparam int unsigned SelW  = (SEL_W > 0) ? SEL_W : 1;
  localparam int unsigned MstW  = $clog2(N_MASTERS);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q  [N_SLAVES];
  state_e            state_d  [N_SLAVES];
  logic [MstW-1:0]   winner_q [N_SLAVES];
  logic [MstW-1:0]   winner_d [N_SLAVES];
  logic [MstW-1:0]   rr_ptr_q [N_SLAVES];
  logic [MstW-1:0]   rr_ptr_d [N_SLAVES];
  logic [15:0]       cnt_q    [N_SLAVES];
  logic [15:0]       cnt_d    [N_SLAVES];

  logic [SelW-1:0]      tgt     [N_MASTERS];
  logic [N_MASTERS-1:0] req_vec [N_SLAVES];
  logic [MstW-1:0]      pick    [N_SLAVES];
  logic                 found   [N_SLAVES];

  // Target slave is taken from the top address bits; a single slave takes everything.
  if (N_SLAVES > 1) begin : g_decode
    always_comb begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        tgt[i] = m_addr[i*ADDR_W + ADDR_W - 1 -: SelW];
      end
    end
  end else begin : g_single
    always_comb begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        tgt[i] = '0;
      end
    end
  end

  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned s = 0; s < N_SLAVES; s++) begin
      req_vec[s] = '0;
      found[s]   = 1'b0;
      pick[s]    = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        req_vec[s][i] = m_req[i] && (tgt[i] == SelW'(s));
      end
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
        if (ARB_MODE == 1) idx = k;
        else               idx = (32'(rr_ptr_q[s]) + k) % N_MASTERS;
        if (!found[s] && req_vec[s][idx]) begin
          found[s] = 1'b1;
          pick[s]  = MstW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < N_SLAVES; s++) begin
      if (arst) begin
        state_q[s]  <= StIdle;
        winner_q[s] <= '0;
        rr_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end else begin
        state_q[s]  <= state_d[s];
        winner_q[s] <= winner_d[s];
        rr_ptr_q[s] <= rr_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < N_SLAVES; s++) begin
      state_d[s]  = state_q[s];
      winner_d[s] = winner_q[s];
      rr_ptr_d[s] = rr_ptr_q[s];
      cnt_d[s]    = cnt_q[s];
      unique case (state_q[s])
        StIdle: begin
          if (found[s]) begin
            state_d[s]  = StBusy;
            winner_d[s] = pick[s];
          end
        end
        StBusy: begin
          if (s_ack[s]) begin
            state_d[s] = StIdle;
            cnt_d[s]   = cnt_q[s] + 16'd1;
            if (ARB_MODE == 0) begin
              rr_ptr_d[s] = (winner_q[s] == MstW'(N_MASTERS - 1)) ? '0 : winner_q[s] + 1'b1;
            end
          end else if (!m_req[winner_q[s]]) begin
            // Winner withdrew: release the slave without counting it.
            state_d[s] = StIdle;
          end
        end
        default: state_d[s] = StIdle;
      endcase
    end
  end

  always_comb begin
    int unsigned wi;
    wi        = 0;
    m_ack     = '0;
    m_rdata   = '0;
    s_req     = '0;
    s_cmd     = '0;
    s_addr    = '0;
    s_wdata   = '0;
    grant_cnt = '0;
    for (int unsigned s = 0; s < N_SLAVES; s++) begin
      grant_cnt[s*16 +: 16] = cnt_q[s];
      if (state_q[s] == StBusy) begin
        wi                          = 32'(winner_q[s]);
        s_req[s]                    = m_req[wi];
        s_cmd[s]                    = m_cmd[wi];
        s_addr[s*ADDR_W +: ADDR_W]  = m_addr[wi*ADDR_W +: ADDR_W];
        s_wdata[s*DATA_W +: DATA_W] = m_wdata[wi*DATA_W +: DATA_W];
        m_ack[wi]                   = m_ack[wi] | s_ack[s];
        m_rdata[wi*DATA_W +: DATA_W] = m_rdata[wi*DATA_W +: DATA_W] | s_rdata[s*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_crossbar_nxm.sv
// Scoreboard bench: a round-robin and a fixed-priority crossbar share master stimulus;
// auto-acking slave models answer with rdata = addr ^ 0xDEADBEFF.
module tb_crossbar_nxm;

  localparam int NM = 2;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic arst;
  logic [NM-1:0]    m_req, m_cmd;
  logic [NM*32-1:0] m_addr, m_wdata;
  logic [NS-1:0]    ack_en, force_ack;

  logic [NM-1:0]    m_ack_rr, m_ack_fp;
  logic [NM*32-1:0] m_rdata_rr, m_rdata_fp;
  logic [NS-1:0]    s_req_rr, s_req_fp, s_cmd_rr, s_cmd_fp, s_ack_rr, s_ack_fp;
  logic [NS*32-1:0] s_addr_rr, s_addr_fp, s_wdata_rr, s_wdata_fp, s_rdata_rr, s_rdata_fp;
  logic [NS*16-1:0] gcnt_rr, gcnt_fp;
  logic [NS-1:0]    seen_rr, seen_fp;

  typedef struct {
    int          m;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_rr[$];
  exp_t exp_fp[$];
  exp_t e_rr, e_fp;
  int   total = 0;
  int   passed = 0;
  int   acks_rr = 0;
  int   acks_fp = 0;

  always #5 clk = ~clk;

  crossbar_nxm #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut_rr (
    .clk(clk), .arst(arst), .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack_rr), .m_rdata(m_rdata_rr), .s_req(s_req_rr), .s_cmd(s_cmd_rr),
    .s_addr(s_addr_rr), .s_wdata(s_wdata_rr), .s_ack(s_ack_rr), .s_rdata(s_rdata_rr),
    .grant_cnt(gcnt_rr)
  );

  crossbar_nxm #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_fp (
    .clk(clk), .arst(arst), .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack_fp), .m_rdata(m_rdata_fp), .s_req(s_req_fp), .s_cmd(s_cmd_fp),
    .s_addr(s_addr_fp), .s_wdata(s_wdata_fp), .s_ack(s_ack_fp), .s_rdata(s_rdata_fp),
    .grant_cnt(gcnt_fp)
  );

  // Slave models ack in the second cycle that s_req is held.
  always @(posedge clk) begin
    if (arst) begin
      seen_rr <= '0;
      seen_fp <= '0;
    end else begin
      seen_rr <= s_req_rr & ~s_ack_rr;
      seen_fp <= s_req_fp & ~s_ack_fp;
    end
  end

  assign s_ack_rr = (s_req_rr & seen_rr & ack_en) | force_ack;
  assign s_ack_fp = (s_req_fp & seen_fp & ack_en) | force_ack;

  always_comb begin
    s_rdata_rr = '0;
    s_rdata_fp = '0;
    for (int s = 0; s < NS; s++) begin
      s_rdata_rr[s*32 +: 32] = s_addr_rr[s*32 +: 32] ^ 32'hDEAD_BEFF;
      s_rdata_fp[s*32 +: 32] = s_addr_fp[s*32 +: 32] ^ 32'hDEAD_BEFF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: got an ack with no expected transaction queued", name);
  endtask

  // Monitor: every m_ack pops the scoreboard of its DUT.
  always @(negedge clk) begin
    if (!arst) begin
      for (int i = 0; i < NM; i++) begin
        if (m_ack_rr[i]) begin
          acks_rr++;
          if (exp_rr.size() == 0) fail_now("rr_unexpected_ack");
          else begin
            e_rr = exp_rr.pop_front();
            check("rr_ack_master", 32'(i), 32'(e_rr.m));
            check("rr_rdata", m_rdata_rr[i*32 +: 32], e_rr.rdata);
          end
        end
        if (m_ack_fp[i]) begin
          acks_fp++;
          if (exp_fp.size() == 0) fail_now("fp_unexpected_ack");
          else begin
            e_fp = exp_fp.pop_front();
            check("fp_ack_master", 32'(i), 32'(e_fp.m));
            check("fp_rdata", m_rdata_fp[i*32 +: 32], e_fp.rdata);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input int m, input logic [31:0] rdata);
    exp_rr.push_back('{m: m, rdata: rdata});
    exp_fp.push_back('{m: m, rdata: rdata});
  endtask

  // Wait (bounded) until both DUTs have delivered `target` acks, then end that cycle.
  task automatic wait_acks(input int target, input string name);
    int n;
    n = 0;
    while ((acks_rr < target || acks_fp < target) && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_rr"}, 32'(acks_rr), 32'(target));
    check({name, "_fp"}, 32'(acks_fp), 32'(target));
    tick();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    arst = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    ack_en = '1; force_ack = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_s_req", {30'd0, s_req_rr}, 32'h0);
    check("rst_m_ack", {30'd0, m_ack_rr}, 32'h0);
    check("rst_gcnt", gcnt_rr, 32'h0);
    check("rst_s_addr", s_addr_rr[31:0], 32'h0);
    check("rst_m_rdata", m_rdata_fp[31:0], 32'h0);

    // Single read by M0 to slave 0
    tick();
    m_req = 2'b01; m_cmd = 2'b00; m_addr[31:0] = 32'h0000_0010;
    push_both(0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("c1_s_req", {30'd0, s_req_rr}, 32'h0);
    tick();
    @(negedge clk);
    check("c2_s_req", {30'd0, s_req_rr}, 32'h1);
    check("c2_s_addr", s_addr_rr[31:0], 32'h0000_0010);
    check("c2_m_ack", {30'd0, m_ack_rr}, 32'h0);
    tick();
    @(negedge clk);
    check("c3_m_ack", {30'd0, m_ack_rr}, 32'h1);
    check("c3_s_req", {30'd0, s_req_fp}, 32'h1);
    tick();
    m_req = 2'b00;
    @(negedge clk);
    check("c4_gcnt", gcnt_rr, 32'h0000_0001);
    check("c4_s_req", {30'd0, s_req_rr}, 32'h0);
    check("c4_m_rdata", m_rdata_rr[31:0], 32'h0);

    // Stray s_ack while idle is ignored
    tick();
    force_ack = 2'b01;
    @(negedge clk);
    check("idle_ack_m_ack", {30'd0, m_ack_rr}, 32'h0);
    tick();
    force_ack = 2'b00;
    @(negedge clk);
    check("idle_ack_gcnt", gcnt_rr, 32'h0000_0001);

    // Both masters write slave 0 continuously: RR alternates, FP always M0
    do_reset();
    base = acks_rr;
    m_req = 2'b11; m_cmd = 2'b11;
    m_addr = {32'h0000_0008, 32'h0000_0004};
    m_wdata = {32'h2222_2222, 32'h1111_1111};
    for (int k = 0; k < 4; k++) begin
      exp_rr.push_back('{m: k % 2, rdata: (k % 2 == 0) ? 32'hDEAD_BEFB : 32'hDEAD_BEF7});
      exp_fp.push_back('{m: 0, rdata: 32'hDEAD_BEFB});
    end
    @(negedge clk);
    tick();
    @(negedge clk);
    check("cont_s_wdata", s_wdata_rr[31:0], 32'h1111_1111);
    check("cont_s_cmd", {30'd0, s_cmd_rr}, 32'h1);
    wait_acks(base + 4, "cont_acks");
    m_req = 2'b00;
    @(negedge clk);
    check("cont_gcnt_rr", gcnt_rr, 32'h0000_0004);
    check("cont_gcnt_fp", gcnt_fp, 32'h0000_0004);

    // Concurrent grants to different slaves
    do_reset();
    base = acks_rr;
    m_req = 2'b11; m_cmd = 2'b00;
    m_addr = {32'h8000_0000, 32'h0000_0000};
    push_both(0, 32'hDEAD_BEFF);
    push_both(1, 32'h5EAD_BEFF);
    @(negedge clk);
    check("par_c1_s_req", {30'd0, s_req_rr}, 32'h0);
    tick();
    @(negedge clk);
    check("par_c2_s_req", {30'd0, s_req_rr}, 32'h3);
    check("par_s1_addr", s_addr_rr[63:32], 32'h8000_0000);
    tick();
    @(negedge clk);
    check("par_c3_m_ack", {30'd0, m_ack_fp}, 32'h3);
    tick();
    m_req = 2'b00;
    @(negedge clk);
    check("par_gcnt", gcnt_rr, 32'h0001_0001);

    // M1 granted, aborts, pending M0 granted next
    do_reset();
    ack_en = 2'b00;
    m_req = 2'b10; m_cmd = 2'b00;
    m_addr = {32'h0000_0008, 32'h0000_0004};
    tick();
    m_req = 2'b11;
    @(negedge clk);
    check("abort_s_addr", s_addr_rr[31:0], 32'h0000_0008);
    tick();
    m_req = 2'b01;
    @(negedge clk);
    check("abort_s_req_drop", {30'd0, s_req_rr}, 32'h0);
    tick();
    ack_en = 2'b11;
    push_both(0, 32'hDEAD_BEFB);
    @(negedge clk);
    check("abort_gcnt", gcnt_rr, 32'h0);
    check("abort_idle_s_req", {30'd0, s_req_fp}, 32'h0);
    tick();
    @(negedge clk);
    check("abort_m0_s_addr", s_addr_rr[31:0], 32'h0000_0004);
    base = acks_rr;
    wait_acks(base + 1, "abort_acks");
    m_req = 2'b00;
    @(negedge clk);
    check("abort_gcnt_after", gcnt_rr, 32'h0000_0001);

    // Reset while busy abandons the transaction
    ack_en = 2'b00;
    m_req = 2'b01; m_addr[31:0] = 32'h0000_0004;
    tick();
    @(negedge clk);
    check("rb_busy_s_req", {30'd0, s_req_rr}, 32'h1);
    tick();
    arst = 1'b1;
    tick();
    arst = 1'b0;
    m_req = 2'b00;
    @(negedge clk);
    check("rb_s_req", {30'd0, s_req_rr}, 32'h0);
    check("rb_gcnt", gcnt_rr, 32'h0);
    check("rb_m_ack", {30'd0, m_ack_rr}, 32'h0);
    tick();
    ack_en = 2'b11;
    m_req = 2'b01;
    push_both(0, 32'hDEAD_BEFB);
    base = acks_rr;
    wait_acks(base + 1, "rb_acks");
    m_req = 2'b00;
    @(negedge clk);
    check("rb_gcnt_after", gcnt_fp, 32'h0000_0001);

    check("rr_queue_drained", 32'(exp_rr.size()), 32'h0);
    check("fp_queue_drained", 32'(exp_fp.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/crossbar_nxm.md
CROSSBAR_NXM -- requirements
Module: crossbar_nxm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 N_MASTERS SHALL default to 2: number of master ports, legal 2..8.
REQ-003 N_SLAVES SHALL default to 2: number of slave ports, power of two, legal 1..8.
REQ-004 ADDR_W SHALL default to 32: address width, greater than or equal to SEL_W+1.
REQ-005 DATA_W SHALL default to 32: write/read data width.
REQ-006 ARB_MODE SHALL default to 0: 0 selects round-robin, 1 selects fixed priority (lowest index wins).
REQ-007 Derived SEL_W SHALL equal clog2(N_SLAVES), or 0 when N_SLAVES=1.
REQ-008 Port clk SHALL be an input, 1 bit wide: the clock, rising edge.
REQ-009 Port arst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-010 Port m_req SHALL be an input, N_MASTERS wide: per-master request.
REQ-011 Port m_cmd SHALL be an input, N_MASTERS wide: per-master command, 1=write, 0=read.
REQ-012 Port m_addr SHALL be an input, N_MASTERS*ADDR_W wide: master i occupies slice [i*ADDR_W +: ADDR_W].
REQ-013 Port m_wdata SHALL be an input, N_MASTERS*DATA_W wide: per-master write data, packed in the same way.
REQ-014 Port m_ack SHALL be an output, N_MASTERS wide: per-master acknowledge.
REQ-015 Port m_rdata SHALL be an output, N_MASTERS*DATA_W wide: per-master read data.
REQ-016 Ports s_req and s_cmd SHALL be outputs, N_SLAVES wide each: per-slave request and command.
REQ-017 Ports s_addr and s_wdata SHALL be outputs, N_SLAVES*ADDR_W and N_SLAVES*DATA_W wide: per-slave address and write data.
REQ-018 Ports s_ack and s_rdata SHALL be inputs, N_SLAVES and N_SLAVES*DATA_W wide: per-slave acknowledge and read data.
REQ-019 Port grant_cnt SHALL be an output, N_SLAVES*16 wide: per-slave count of completed transactions.

Function
REQ-020 Target slave of master i SHALL be m_addr[i][ADDR_W-1 -: SEL_W]; with N_SLAVES=1, all requests SHALL target slave 0.
REQ-021 Protocol: a master SHALL hold req/cmd/addr/wdata stable until it samples ack=1; ack SHALL be a single-cycle pulse; rdata SHALL be valid only in the ack cycle.
REQ-022 Each slave SHALL own an independent arbiter FSM with states IDLE and BUSY, plus a registered winner index.
REQ-023 IDLE: if at least one master requests this slave, the FSM SHALL register the winner and enter BUSY at the next edge; otherwise it SHALL stay in IDLE.
REQ-024 Round-robin mode: the search SHALL start at rr_ptr; on each completion rr_ptr SHALL become winner+1 modulo N_MASTERS.
REQ-025 Fixed-priority mode: the lowest requesting index SHALL win; rr_ptr SHALL be unused.
REQ-026 BUSY: s_req/s_cmd/s_addr/s_wdata SHALL be driven combinationally from the winner.
REQ-027 BUSY: s_ack and s_rdata SHALL be routed combinationally to the winner's m_ack and m_rdata.
REQ-028 BUSY with s_ack=1 SHALL return the FSM to IDLE, advance rr_ptr, and increment grant_cnt (wrapping 0xFFFF->0).
REQ-029 BUSY with the winner's m_req=0 (abort) SHALL return the FSM to IDLE with no pointer or count update.
REQ-030 Arbitration latency SHALL be 1 cycle: s_req rises in the cycle after m_req is first seen; the minimum transaction is 2 cycles.
REQ-031 Back-to-back completions SHALL be supported: after IDLE is re-entered, a new grant SHALL follow on the next edge.
REQ-032 Grants to different slaves SHALL proceed concurrently with no interaction.
REQ-033 A master that is not granted SHALL see m_ack=0 and m_rdata=0.
REQ-034 An idle slave port SHALL drive s_req=0, s_cmd=0, s_addr=0 and s_wdata=0.
REQ-035 s_ack received while IDLE SHALL be ignored.

Reset
REQ-036 When arst=1 at a clk edge, all FSMs SHALL go to IDLE, all winners and rr_ptr SHALL be 0, and grant_cnt SHALL be 0.
REQ-037 After the reset edge, all s_req/m_ack SHALL be 0 and all data outputs SHALL be 0.
REQ-038 Reset during BUSY SHALL abandon the transaction with no ack delivered; masters SHALL re-issue.

Verification
REQ-039 Defaults, M0 read of 0x0000_0010 (slave 0), slave acks with rdata 0xDEAD_BEEF in cycle 3 -> s_req0 high cycles 2-3, m_ack[0]=1 and m_rdata0=0xDEAD_BEEF in cycle 3, grant_cnt0=1.
REQ-040 M0 and M1 both write slave 0 continuously, RR mode -> grants alternate M0,M1,M0,M1; after 4 acks grant_cnt0=4.
REQ-041 Same stimulus with ARB_MODE=1 -> M0 wins every grant; M1 is never acked while M0 holds req.
REQ-042 M0 targets 0x0000_0000 and M1 targets 0x8000_0000 in the same cycle -> both s_req rise in the next cycle, and both acks return independently.
REQ-043 M1 granted, then drops req before ack -> FSM returns to IDLE, grant_cnt unchanged, and a pending M0 is granted next.
REQ-044 arst asserted during BUSY -> s_req=0 after the edge, grant_cnt=0, and a fresh request after reset completes normally.
